// File: rtl/memswap_pkg.sv
// Shared definitions for block_memory_swapper: opcodes and engine state encoding.
// Build option: BLOCK_MEMSWAP_COPY_EN enables the COPY opcode and CPY state.
package memswap_pkg;

   localparam logic OP_SWAP = 1'b0;
   localparam logic OP_COPY = 1'b1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      WR_A = 3'd2,
      WR_B = 3'd3,
      CPY  = 3'd4,
      DONE = 3'd5
   } state_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// 2^N x BITS register file with one muxed write port and two asynchronous read ports.
// While the engine is busy it owns the write port; otherwise the external port writes.
module reg_file_2r1w #(
   parameter int N    = 8,
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            busy,
   input  logic            ext_we,
   input  logic [N-1:0]    ext_address_w,
   input  logic [BITS-1:0] ext_data_w,
   input  logic            eng_we,
   input  logic [N-1:0]    eng_address_w,
   input  logic [BITS-1:0] eng_data_w,
   input  logic [N-1:0]    ext_address_r,
   output logic [BITS-1:0] ext_data_r,
   input  logic [N-1:0]    eng_address_r,
   output logic [BITS-1:0] eng_data_r
);

   logic [BITS-1:0] mem [2**N];
   logic            wr_en;
   logic [N-1:0]    wr_address;
   logic [BITS-1:0] wr_data;

   // Select the write source: the engine while busy, the external port when idle
   always_comb begin
      wr_en      = ext_we;
      wr_address = ext_address_w;
      wr_data    = ext_data_w;
      if (busy) begin
         wr_en      = eng_we;
         wr_address = eng_address_w;
         wr_data    = eng_data_w;
      end
   end

   // Storage array; contents deliberately have no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_address] <= wr_data;
   end

   assign ext_data_r = mem[ext_address_r];
   assign eng_data_r = mem[eng_address_r];

endmodule

// File: rtl/block_memory_swapper.sv
// Register file with a block SWAP (and optional COPY) command engine.
// Build option: BLOCK_MEMSWAP_COPY_EN adds the COPY opcode; without it COPY is rejected.
module block_memory_swapper #(
   parameter int N    = 8,
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            we,
   input  logic [N-1:0]    address_w,
   input  logic [BITS-1:0] data_w,
   input  logic [N-1:0]    address_r,
   output logic [BITS-1:0] data_r,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_op,
   input  logic [N-1:0]    address_A,
   input  logic [N-1:0]    address_B,
   input  logic [N-1:0]    cmd_len,
   output logic            busy,
   output logic            done,
   output logic            err
);
   import memswap_pkg::*;

   localparam logic [N:0] DEPTH_EXT = {1'b1, {N{1'b0}}};

   state_t          state;
   logic [N-1:0]    a_q, b_q, len_q, idx;
   logic [BITS-1:0] tmp;

   logic [N:0]      end_a, end_b;
   logic            range_bad, overlap, op_bad, reject, trivial, last;
   logic [N-1:0]    addr_a, addr_b, eng_address_r, eng_address_w;
   logic [BITS-1:0] eng_data_r, eng_data_w;
   logic            eng_we;

   // Range ends are formed one bit wider so a block running past the top cannot wrap
   assign end_a     = {1'b0, address_A} + {1'b0, cmd_len};
   assign end_b     = {1'b0, address_B} + {1'b0, cmd_len};
   assign range_bad = (end_a > DEPTH_EXT) || (end_b > DEPTH_EXT);
   assign overlap   = (cmd_len != '0) && (address_A != address_B) &&
                      ({1'b0, address_A} < end_b) && ({1'b0, address_B} < end_a);
`ifdef BLOCK_MEMSWAP_COPY_EN
   assign op_bad    = 1'b0;
`else
   assign op_bad    = (cmd_op == OP_COPY);
`endif
   assign reject    = range_bad || overlap || op_bad;
   assign trivial   = (cmd_len == '0) || (address_A == address_B);

   assign addr_a        = a_q + idx;
   assign addr_b        = b_q + idx;
   assign last          = (idx == len_q - 1'b1);
   assign eng_address_r = (state == WR_A) ? addr_b : addr_a;

   // Engine write port: A side gets B's word, B side gets tmp (or A's word on copy)
   always_comb begin
      eng_we        = 1'b0;
      eng_address_w = addr_a;
      eng_data_w    = eng_data_r;
      case (state)
         WR_A: eng_we = 1'b1;
         WR_B: begin
            eng_we        = 1'b1;
            eng_address_w = addr_b;
            eng_data_w    = tmp;
         end
`ifdef BLOCK_MEMSWAP_COPY_EN
         CPY: begin
            eng_we        = 1'b1;
            eng_address_w = addr_b;
         end
`endif
         default: eng_we = 1'b0;
      endcase
   end

   reg_file_2r1w #(.N(N), .BITS(BITS)) u_mem (
      .clk           (clk),
      .busy          (busy),
      .ext_we        (we),
      .ext_address_w (address_w),
      .ext_data_w    (data_w),
      .eng_we        (eng_we),
      .eng_address_w (eng_address_w),
      .eng_data_w    (eng_data_w),
      .ext_address_r (address_r),
      .ext_data_r    (data_r),
      .eng_address_r (eng_address_r),
      .eng_data_r    (eng_data_r)
   );

   // Command FSM with registered status; err flags rejected commands and dropped writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         tmp       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         len_q     <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= we && busy;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (reject) begin
                     err <= 1'b1;
                  end else begin
                     a_q       <= address_A;
                     b_q       <= address_B;
                     len_q     <= cmd_len;
                     idx       <= '0;
                     busy      <= 1'b1;
                     cmd_ready <= 1'b0;
                     if (trivial) begin
                        state <= DONE;
                        done  <= 1'b1;
`ifdef BLOCK_MEMSWAP_COPY_EN
                     end else if (cmd_op == OP_COPY) begin
                        state <= CPY;
`endif
                     end else begin
                        state <= RD_A;
                     end
                  end
               end
            end
            RD_A: begin
               tmp   <= eng_data_r;
               state <= WR_A;
            end
            WR_A: state <= WR_B;
            WR_B: begin
               idx <= idx + 1'b1;
               if (last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= RD_A;
               end
            end
`ifdef BLOCK_MEMSWAP_COPY_EN
            CPY: begin
               idx <= idx + 1'b1;
               if (last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
`endif
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
